// File: rtl/draw_scheduler_if.sv
// Bundle between the draw scheduler, its four rectangle engines and the VGA adapter port.
// The slave modport is the scheduler's view; master is the engines/adapter side.
interface draw_scheduler_if;
  logic [3:0]  req;
  logic [3:0]  eng_done;
  logic [35:0] eng_x;
  logic [31:0] eng_y;
  logic [11:0] eng_colour;
  logic [3:0]  eng_enable;
  logic [3:0]  eng_reset_n;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [3:0]  ack;
  logic        err;
  logic        busy;

  modport slave (
    input  req, eng_done, eng_x, eng_y, eng_colour,
    output eng_enable, eng_reset_n, vga_x, vga_y, vga_colour, vga_plot, ack, err, busy
  );

  modport master (
    output req, eng_done, eng_x, eng_y, eng_colour,
    input  eng_enable, eng_reset_n, vga_x, vga_y, vga_colour, vga_plot, ack, err, busy
  );
endinterface

// File: rtl/draw_scheduler.sv
// Round-robin owner of the single VGA write port across four rectangle-draw engines,
// with ROM-latency realignment, screen clipping and colour-key transparency.
//
// state | meaning
// IDLE  | all engines held in reset, waiting for a request
// DRAW  | granted engine enabled, one pixel per cycle into the pipeline
// FLUSH | two cycles to drain the coordinate/colour pipeline
// ACK   | one-cycle ack (and err on timeout), granted engine rewound
module draw_scheduler #(
  parameter int unsigned SCREEN_W      = 320,
  parameter int unsigned SCREEN_H      = 240,
  parameter bit          TRANSP_EN     = 1'b1,
  parameter logic [2:0]  TRANSP_COLOUR = 3'b000,
  parameter logic [15:0] TIMEOUT       = 16'd65535
) (
  input logic              clock_all,
  input logic              reset_all,
  draw_scheduler_if.slave  sched
);

  localparam logic [9:0] W_LIM = 10'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, ACK} state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_ptr;
  logic        r_flush;
  logic        r_abort;
  logic [15:0] r_tmo;
  logic        r_pv;
  logic [8:0]  r_px;
  logic [7:0]  r_py;

  logic [8:0]  w_ex [4];
  logic [7:0]  w_ey [4];
  logic [2:0]  w_ec [4];
  logic [2:0]  w_col;
  logic [15:0] w_tmo_next;
  logic        w_plot;
  logic        w_found;
  logic [1:0]  w_pick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign w_ex[gi] = sched.eng_x[9*gi +: 9];
    assign w_ey[gi] = sched.eng_y[8*gi +: 8];
    assign w_ec[gi] = sched.eng_colour[3*gi +: 3];
  end

  // Colour arrives one cycle after its coordinate, so it pairs with the pipeline stage.
  assign w_col      = w_ec[r_grant];
  assign w_tmo_next = r_tmo + 16'd1;
  assign w_plot     = r_pv && ({1'b0, r_px} < W_LIM) && ({1'b0, r_py} < H_LIM) &&
                      !(TRANSP_EN && (w_col == TRANSP_COLOUR));

  always_comb begin
    logic [1:0] v_idx;
    v_idx   = r_ptr;
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int i = 0; i < 4; i++) begin
      v_idx = r_ptr + 2'(i);
      if (!w_found && sched.req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_ff @(posedge clock_all) begin
    if (!reset_all) begin
      r_state           <= IDLE;
      r_grant           <= 2'd0;
      r_ptr             <= 2'd0;
      r_flush           <= 1'b0;
      r_abort           <= 1'b0;
      r_tmo             <= 16'd0;
      r_pv              <= 1'b0;
      r_px              <= 9'd0;
      r_py              <= 8'd0;
      sched.eng_enable  <= 4'd0;
      sched.eng_reset_n <= 4'd0;
      sched.vga_x       <= 9'd0;
      sched.vga_y       <= 8'd0;
      sched.vga_colour  <= 3'd0;
      sched.vga_plot    <= 1'b0;
      sched.ack         <= 4'd0;
      sched.err         <= 1'b0;
      sched.busy        <= 1'b0;
    end else begin
      sched.ack      <= 4'd0;
      sched.err      <= 1'b0;
      r_pv           <= 1'b0;
      sched.vga_plot <= w_plot;
      // Masked pixels still move the coordinates; only the strobe is suppressed.
      if (r_pv) begin
        sched.vga_x      <= r_px;
        sched.vga_y      <= r_py;
        sched.vga_colour <= w_col;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant           <= w_pick;
            r_tmo             <= 16'd0;
            r_abort           <= 1'b0;
            sched.eng_enable  <= onehot(w_pick);
            sched.eng_reset_n <= onehot(w_pick);
            sched.busy        <= 1'b1;
            r_state           <= DRAW;
          end
        end
        DRAW: begin
          r_pv  <= 1'b1;
          r_px  <= w_ex[r_grant];
          r_py  <= w_ey[r_grant];
          r_tmo <= w_tmo_next;
          if (sched.eng_done[r_grant]) begin
            sched.eng_enable <= 4'd0;
            r_flush          <= 1'b0;
            r_state          <= FLUSH;
          end else if (w_tmo_next == TIMEOUT) begin
            sched.eng_enable <= 4'd0;
            r_flush          <= 1'b0;
            r_abort          <= 1'b1;
            r_state          <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_flush) begin
            sched.ack         <= onehot(r_grant);
            sched.err         <= r_abort;
            sched.eng_reset_n <= 4'd0;
            r_state           <= ACK;
          end else begin
            r_flush <= 1'b1;
          end
        end
        ACK: begin
          r_ptr      <= r_grant + 2'd1;
          sched.busy <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: behavioural rectangle engines feed two scheduler
// instances (default build, and TRANSP_EN=0 with a short timeout).
module tb_draw_scheduler;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  draw_scheduler_if ifa ();
  draw_scheduler_if ifb ();

  draw_scheduler dut_a (.clock_all(clk), .reset_all(rst_a), .sched(ifa));
  draw_scheduler #(.TRANSP_EN(1'b0), .TIMEOUT(16'd100)) dut_b (
    .clock_all(clk), .reset_all(rst_b), .sched(ifb));

  // Engine models: engines 0..3 serve dut_a, 4..7 serve dut_b.
  int         bx [8], by [8], ew [8], eh [8], mode [8];
  bit         nodone [8];
  int         cx [8] = '{default: 0};
  int         cy [8] = '{default: 0};
  logic [2:0] col [8] = '{default: 3'd0};
  logic [7:0] m_rn, m_en;

  assign m_rn = {ifb.eng_reset_n, ifa.eng_reset_n};
  assign m_en = {ifb.eng_enable, ifa.eng_enable};

  function automatic logic [2:0] rom(input int m, input int x, input int y);
    if (m == 1) return (x % 2 == 1) ? 3'b111 : 3'b000;
    return 3'((x + y) % 7 + 1);
  endfunction

  always @(posedge clk) begin
    for (int e = 0; e < 8; e++) begin
      col[e] <= rom(mode[e], cx[e], cy[e]);
      if (!m_rn[e]) begin
        cx[e] <= 0;
        cy[e] <= 0;
      end else if (m_en[e]) begin
        if (cx[e] == ew[e] - 1) begin
          cx[e] <= 0;
          cy[e] <= (cy[e] == eh[e] - 1) ? 0 : cy[e] + 1;
        end else begin
          cx[e] <= cx[e] + 1;
        end
      end
    end
  end

  always_comb begin
    ifa.eng_x = '0; ifa.eng_y = '0; ifa.eng_colour = '0; ifa.eng_done = '0;
    ifb.eng_x = '0; ifb.eng_y = '0; ifb.eng_colour = '0; ifb.eng_done = '0;
    for (int e = 0; e < 4; e++) begin
      ifa.eng_x[9*e +: 9]      = 9'(bx[e] + cx[e]);
      ifa.eng_y[8*e +: 8]      = 8'(by[e] + cy[e]);
      ifa.eng_colour[3*e +: 3] = col[e];
      ifa.eng_done[e]          = !nodone[e] && (cx[e] == ew[e] - 1) && (cy[e] == eh[e] - 1);
      ifb.eng_x[9*e +: 9]      = 9'(bx[e+4] + cx[e+4]);
      ifb.eng_y[8*e +: 8]      = 8'(by[e+4] + cy[e+4]);
      ifb.eng_colour[3*e +: 3] = col[e+4];
      ifb.eng_done[e]          = !nodone[e+4] && (cx[e+4] == ew[e+4] - 1) && (cy[e+4] == eh[e+4] - 1);
    end
  end

  // Observation, sampled on the falling edge.
  int plots [2], en_cyc [2], gseen [2], acks [2], ack_v [2], err_v [2];
  int ack_cyc [2], done_cyc [2], first_en [2], first_plot [2], fx [2], fy [2];
  int last_x [2], last_y [2];
  int clip_bad [2] = '{0, 0};
  int onehot_bad [2] = '{0, 0};
  int err_alone [2] = '{0, 0};
  int checks = 0;
  int errors = 0;

  task automatic clr(input int k);
    plots[k] = 0; en_cyc[k] = 0; gseen[k] = -1; acks[k] = 0; ack_v[k] = 0; err_v[k] = 0;
    ack_cyc[k] = -1; done_cyc[k] = -1; first_en[k] = -1; first_plot[k] = -1;
    fx[k] = -1; fy[k] = -1; last_x[k] = -1; last_y[k] = -1;
  endtask

  task automatic mon(input int k, input logic [3:0] en, input logic [3:0] done, input logic plot,
                     input logic [8:0] x, input logic [7:0] y, input logic [3:0] ack, input logic err);
    if ($countones(en) > 1) onehot_bad[k]++;
    if (en != 4'd0) begin
      en_cyc[k]++;
      if (first_en[k] < 0) first_en[k] = cyc;
      for (int i = 0; i < 4; i++) if (en[i]) gseen[k] = i;
    end
    if (((done & en) != 4'd0) && done_cyc[k] < 0) done_cyc[k] = cyc;
    if (plot) begin
      plots[k]++;
      if (x >= 9'd320 || y >= 8'd240) clip_bad[k]++;
      if (first_plot[k] < 0) begin
        first_plot[k] = cyc; fx[k] = int'(x); fy[k] = int'(y);
      end
    end
    if (err && ack == 4'd0) err_alone[k]++;
    if (ack != 4'd0) begin
      acks[k]++; ack_v[k] = int'(ack); err_v[k] = int'(err); ack_cyc[k] = cyc;
      last_x[k] = int'(x); last_y[k] = int'(y);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.eng_enable, ifa.eng_done, ifa.vga_plot, ifa.vga_x, ifa.vga_y, ifa.ack, ifa.err);
    mon(1, ifb.eng_enable, ifb.eng_done, ifb.vga_plot, ifb.vga_x, ifb.vga_y, ifb.ack, ifb.err);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input int k, input int budget);
    int n;
    n = 0;
    while (acks[k] == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (acks[k] == 0) chk($sformatf("ack_wait_inst%0d", k), 0, 1);
  endtask

  task automatic cfg(input int e, input int x, input int y, input int w, input int h,
                     input int m, input bit nd);
    bx[e] = x; by[e] = y; ew[e] = w; eh[e] = h; mode[e] = m; nodone[e] = nd;
  endtask

  typedef struct {
    logic [3:0] req;
    int eng, x, y, w, h, m;
    int g, plots, lx, ly;
  } row_t;

  row_t rows [9];

  initial begin
    int n;
    rows[0] = '{4'b1111, 0,  10,  10, 2, 2, 0, 0, 4,  11,  11};
    rows[1] = '{4'b1111, 1, 316,  20, 8, 2, 0, 1, 8, 323,  21};
    rows[2] = '{4'b1111, 2,  50,  60, 6, 1, 1, 2, 3,  55,  60};
    rows[3] = '{4'b1111, 3,  10,  10, 2, 2, 0, 3, 4,  11,  11};
    rows[4] = '{4'b1111, 0,   5, 238, 2, 4, 0, 0, 4,   6, 241};
    rows[5] = '{4'b0100, 2,  10,  10, 2, 2, 0, 2, 4,  11,  11};
    rows[6] = '{4'b0011, 0,  10,  10, 2, 2, 0, 0, 4,  11,  11};
    rows[7] = '{4'b0011, 1,  10,  10, 2, 2, 0, 1, 4,  11,  11};
    rows[8] = '{4'b0011, 0,  10,  10, 2, 2, 0, 0, 4,  11,  11};

    for (int e = 0; e < 8; e++) cfg(e, 10, 10, 2, 2, 0, 1'b0);
    ifa.req = 4'd0;
    ifb.req = 4'd0;
    clr(0);
    clr(1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enable", int'(ifa.eng_enable), 0);
    chk("rst_reset_n", int'(ifa.eng_reset_n), 0);
    chk("rst_vga", int'({ifa.vga_x, ifa.vga_y, ifa.vga_colour, ifa.vga_plot}), 0);
    chk("rst_ack_err", int'({ifa.ack, ifa.err}), 0);
    chk("rst_busy", int'(ifa.busy), 0);

    // Full HP-bar draw.
    rst_a = 1'b1;
    cfg(3, 0, 0, 137, 37, 0, 1'b0);
    clr(0);
    ifa.req = 4'b1000;
    wait_ack(0, 8000);
    ifa.req = 4'd0;
    chk("hp_plots", plots[0], 5069);
    chk("hp_first_x", fx[0], 0);
    chk("hp_first_y", fy[0], 0);
    chk("hp_first_latency", first_plot[0] - first_en[0], 2);
    chk("hp_enable_cycles", en_cyc[0], 5069);
    chk("hp_ack_after_done", ack_cyc[0] - done_cyc[0], 3);
    chk("hp_ack_vec", ack_v[0], 8);
    chk("hp_err", err_v[0], 0);
    repeat (4) @(negedge clk);
    #1;
    chk("hp_ack_count", acks[0], 1);

    // Reset in the middle of the same draw.
    clr(0);
    ifa.req = 4'b1000;
    n = 0;
    while (plots[0] < 2000 && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_reached_2000", plots[0], 2000);
    rst_a = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_enable", int'(ifa.eng_enable), 0);
    chk("mid_rst_reset_n", int'(ifa.eng_reset_n), 0);
    chk("mid_rst_vga", int'({ifa.vga_x, ifa.vga_y, ifa.vga_colour, ifa.vga_plot}), 0);
    chk("mid_rst_busy", int'(ifa.busy), 0);
    @(negedge clk); #1;
    chk("mid_no_ack", acks[0], 0);
    clr(0);
    rst_a = 1'b1;
    wait_ack(0, 8000);
    ifa.req = 4'd0;
    chk("restart_first_x", fx[0], 0);
    chk("restart_first_y", fy[0], 0);
    chk("restart_plots", plots[0], 5069);

    // Arbitration, clipping and transparency table.
    for (int r = 0; r < 9; r++) begin
      cfg(rows[r].eng, rows[r].x, rows[r].y, rows[r].w, rows[r].h, rows[r].m, 1'b0);
      clr(0);
      ifa.req = rows[r].req;
      wait_ack(0, 200);
      chk($sformatf("row%0d_grant", r), gseen[0], rows[r].g);
      chk($sformatf("row%0d_ack", r), ack_v[0], 1 << rows[r].g);
      chk($sformatf("row%0d_err", r), err_v[0], 0);
      chk($sformatf("row%0d_plots", r), plots[0], rows[r].plots);
      chk($sformatf("row%0d_last_x", r), last_x[0], rows[r].lx);
      chk($sformatf("row%0d_last_y", r), last_y[0], rows[r].ly);
    end
    ifa.req = 4'd0;

    // Second instance: transparency disabled, then a forced timeout.
    rst_b = 1'b1;
    cfg(4, 50, 60, 6, 1, 1, 1'b0);
    clr(1);
    ifb.req = 4'b0001;
    wait_ack(1, 100);
    ifb.req = 4'd0;
    chk("notransp_plots", plots[1], 6);
    chk("notransp_ack", ack_v[1], 1);
    chk("notransp_err", err_v[1], 0);

    cfg(5, 0, 0, 200, 200, 0, 1'b1);
    cfg(6, 10, 10, 2, 2, 0, 1'b0);
    clr(1);
    ifb.req = 4'b0110;
    wait_ack(1, 300);
    chk("tmo_grant", gseen[1], 1);
    chk("tmo_enable_cycles", en_cyc[1], 100);
    chk("tmo_plots", plots[1], 100);
    chk("tmo_ack", ack_v[1], 2);
    chk("tmo_err", err_v[1], 1);
    clr(1);
    wait_ack(1, 100);
    ifb.req = 4'd0;
    chk("after_tmo_ack", ack_v[1], 4);
    chk("after_tmo_err", err_v[1], 0);
    chk("after_tmo_plots", plots[1], 4);

    repeat (4) @(negedge clk);
    #1;
    chk("onehot_a", onehot_bad[0], 0);
    chk("onehot_b", onehot_bad[1], 0);
    chk("clip_a", clip_bad[0], 0);
    chk("err_without_ack_a", err_alone[0], 0);
    chk("err_without_ack_b", err_alone[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
